// File: rtl/ptp_rtc_pkg.sv
// PTP real-time clock shared definitions.
// Register offsets, time constants, CSR bit positions.
package ptp_rtc_pkg;

  localparam logic [7:0] ADDR_CONTROL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_INC_NS    = 8'h08;
  localparam logic [7:0] ADDR_INC_FRAC  = 8'h0C;
  localparam logic [7:0] ADDR_SH_SEC_HI = 8'h10;
  localparam logic [7:0] ADDR_SH_SEC_LO = 8'h14;
  localparam logic [7:0] ADDR_SH_NS     = 8'h18;
  localparam logic [7:0] ADDR_TOD_CMD   = 8'h1C;
  localparam logic [7:0] ADDR_ADJ       = 8'h20;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
  localparam logic [31:0] NS_MAX     = 32'd999_999_999;
  localparam logic [29:0] ADJ_MAX    = 30'd999_999_999;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_IRQ_BIT  = 1;
  localparam int CTRL_SRST_BIT = 31;
  localparam int CMD_LOAD_BIT  = 0;
  localparam int CMD_SNAP_BIT  = 1;
  localparam int ADJ_SIGN_BIT  = 31;

  function automatic logic [29:0] adj_clamp(
    input logic [29:0] m
  );
    return (m > ADJ_MAX) ? ADJ_MAX : m;
  endfunction

endpackage

// File: rtl/rtc_tod_counter.sv
// Time-of-day counter: frac/ns/sec arithmetic, load, offset adjust, pps.
// Ports: clk/rst, enable+increments, load values, adjust, sec/ns, roll/pps.
module rtc_tod_counter
  import ptp_rtc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  inc_ns_i,
  input  logic [31:0] inc_frac_i,
  input  logic        load_i,
  input  logic [47:0] ld_sec_i,
  input  logic [31:0] ld_ns_i,
  input  logic        adj_vld_i,
  input  logic        adj_neg_i,
  input  logic [29:0] adj_mag_i,
  output logic [47:0] sec_o,
  output logic [31:0] ns_o,
  output logic        roll_o,
  output logic        pps_o
);

  localparam logic signed [33:0] ONE_SEC = 34'sd1_000_000_000;
  localparam logic signed [33:0] TWO_SEC = 34'sd2_000_000_000;

  logic [31:0] frac_q, frac_d;
  logic [31:0] ns_q, ns_d;
  logic [47:0] sec_q, sec_d;
  logic        pps_q, pps_d;
  logic        roll;
  logic [32:0] fsum;
  logic signed [33:0] adj_s, t;

  always_comb begin
    fsum   = {1'b0, frac_q} + {1'b0, inc_frac_i};
    adj_s  = '0;
    if (adj_vld_i) begin
      adj_s = adj_neg_i ? -$signed({4'b0, adj_mag_i})
                        :  $signed({4'b0, adj_mag_i});
    end
    t = $signed({2'b0, ns_q}) + adj_s;
    if (en_i) begin
      t = t + $signed({26'b0, inc_ns_i})
            + $signed({33'b0, fsum[32]});
    end
    frac_d = en_i ? fsum[31:0] : frac_q;
    ns_d   = t[31:0];
    sec_d  = sec_q;
    roll   = 1'b0;
    if (load_i) begin
      frac_d = '0;
      sec_d  = ld_sec_i;
      ns_d   = (ld_ns_i > NS_MAX) ? NS_MAX : ld_ns_i;
    end else if (t >= TWO_SEC) begin
      // max positive adjust on top of a near-full second
      ns_d  = t[31:0] - 32'd2_000_000_000;
      sec_d = sec_q + 48'd2;
      roll  = 1'b1;
    end else if (t >= ONE_SEC) begin
      ns_d  = t[31:0] - NS_PER_SEC;
      sec_d = sec_q + 48'd1;
      roll  = 1'b1;
    end else if (t[33]) begin
      ns_d  = t[31:0] + NS_PER_SEC;
      sec_d = sec_q - 48'd1;
    end
    pps_d = roll;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frac_q <= '0;
      ns_q   <= '0;
      sec_q  <= '0;
      pps_q  <= 1'b0;
    end else begin
      frac_q <= frac_d;
      ns_q   <= ns_d;
      sec_q  <= sec_d;
      pps_q  <= pps_d;
    end
  end

  assign sec_o  = sec_q;
  assign ns_o   = ns_q;
  assign roll_o = roll;
  assign pps_o  = pps_q;

endmodule

// File: rtl/apb_ptp_rtc.sv
// APB responder for the PTP real-time clock: decode, CSRs, shadows, IRQ.
// Ports: APB slave (no PREADY), IRQ, rtc_pps, live rtc_sec/rtc_ns.
module apb_ptp_rtc
  import ptp_rtc_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = 8
)(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ,
  output logic        rtc_pps,
  output logic [47:0] rtc_sec,
  output logic [31:0] rtc_ns
);

  localparam logic [7:0] INC_RST = 8'(CLK_PERIOD_NS);

  logic        en_q, irq_en_q, pps_st_q;
  logic [7:0]  inc_ns_q;
  logic [31:0] inc_frac_q;
  logic [47:0] sh_sec_q;
  logic [31:0] sh_ns_q;
  logic        load_q, adj_vld_q, adj_neg_q;
  logic [29:0] adj_mag_q;
  logic [31:0] prdata_q, rdata_d;
  logic        wr, rd, srst, cnt_roll;
  logic [7:0]  addr;
  logic        unused_paddr;

  assign addr = PADDR[7:0];
  assign unused_paddr = ^PADDR[31:8];
  assign wr   = PSEL & PENABLE & PWRITE;
  assign rd   = PSEL & ~PENABLE & ~PWRITE;
  // soft reset acts at the write edge so the next cycle is in reset state
  assign srst = PRESET
              | (wr & (addr == ADDR_CONTROL) & PWDATA[CTRL_SRST_BIT]);

  always_comb begin
    rdata_d = '0;
    unique case (addr)
      ADDR_CONTROL:   rdata_d = {30'b0, irq_en_q, en_q};
      ADDR_STATUS:    rdata_d = {31'b0, pps_st_q};
      ADDR_INC_NS:    rdata_d = {24'b0, inc_ns_q};
      ADDR_INC_FRAC:  rdata_d = inc_frac_q;
      ADDR_SH_SEC_HI: rdata_d = {16'b0, sh_sec_q[47:32]};
      ADDR_SH_SEC_LO: rdata_d = sh_sec_q[31:0];
      ADDR_SH_NS:     rdata_d = sh_ns_q;
      default:        rdata_d = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (srst) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pps_st_q   <= 1'b0;
      inc_ns_q   <= INC_RST;
      inc_frac_q <= '0;
      sh_sec_q   <= '0;
      sh_ns_q    <= '0;
      load_q     <= 1'b0;
      adj_vld_q  <= 1'b0;
      adj_neg_q  <= 1'b0;
      adj_mag_q  <= '0;
      prdata_q   <= '0;
    end else begin
      load_q    <= 1'b0;
      adj_vld_q <= 1'b0;
      if (rd) prdata_q <= rdata_d;
      if (wr) begin
        unique case (addr)
          ADDR_CONTROL: begin
            en_q     <= PWDATA[CTRL_EN_BIT];
            irq_en_q <= PWDATA[CTRL_IRQ_BIT];
          end
          ADDR_STATUS:    if (PWDATA[0]) pps_st_q <= 1'b0;
          ADDR_INC_NS:    inc_ns_q <= PWDATA[7:0];
          ADDR_INC_FRAC:  inc_frac_q <= PWDATA;
          ADDR_SH_SEC_HI: sh_sec_q[47:32] <= PWDATA[15:0];
          ADDR_SH_SEC_LO: sh_sec_q[31:0] <= PWDATA;
          ADDR_SH_NS:     sh_ns_q <= PWDATA;
          ADDR_TOD_CMD: begin
            load_q <= PWDATA[CMD_LOAD_BIT];
            // load wins; snapshot sees the pre-update counter
            if (PWDATA[CMD_SNAP_BIT] && !PWDATA[CMD_LOAD_BIT]) begin
              sh_sec_q <= rtc_sec;
              sh_ns_q  <= rtc_ns;
            end
          end
          ADDR_ADJ: begin
            adj_vld_q <= 1'b1;
            adj_neg_q <= PWDATA[ADJ_SIGN_BIT];
            adj_mag_q <= adj_clamp(PWDATA[29:0]);
          end
          default: ;
        endcase
      end
      // rollover set beats a same-cycle clear
      if (cnt_roll) pps_st_q <= 1'b1;
    end
  end

  rtc_tod_counter u_tod (
    .clk_i      (PCLK),
    .rst_i      (srst),
    .en_i       (en_q),
    .inc_ns_i   (inc_ns_q),
    .inc_frac_i (inc_frac_q),
    .load_i     (load_q),
    .ld_sec_i   (sh_sec_q),
    .ld_ns_i    (sh_ns_q),
    .adj_vld_i  (adj_vld_q),
    .adj_neg_i  (adj_neg_q),
    .adj_mag_i  (adj_mag_q),
    .sec_o      (rtc_sec),
    .ns_o       (rtc_ns),
    .roll_o     (cnt_roll),
    .pps_o      (rtc_pps)
  );

  assign PRDATA = prdata_q;
  assign IRQ    = pps_st_q & irq_en_q;

endmodule

// File: tb/tb_apb_ptp_rtc.sv
// Self-checking bench for apb_ptp_rtc.
// Read expectations go through a queue; counter values checked per cycle.
module tb_apb_ptp_rtc;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ, rtc_pps;
  logic [47:0] rtc_sec;
  logic [31:0] rtc_ns;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ns_q[$];

  always #5 PCLK = ~PCLK;

  apb_ptp_rtc #(.CLK_PERIOD_NS(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ),
    .rtc_pps (rtc_pps),
    .rtc_sec (rtc_sec),
    .rtc_ns  (rtc_ns)
  );

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {24'b0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input string tag, input logic [7:0] a,
                        input logic [31:0] exp);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {24'b0, a};
    exp_q.push_back(exp);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk(tag, {32'b0, PRDATA}, {32'b0, exp_q.pop_front()});
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic load_tod(input logic [47:0] s, input logic [31:0] n);
    apb_wr(8'h10, {16'b0, s[47:32]});
    apb_wr(8'h14, s[31:0]);
    apb_wr(8'h18, n);
    apb_wr(8'h1C, 32'h1);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    tick(3);
    chk("rst_irq", {63'b0, IRQ}, 64'd0);
    chk("rst_ns", {32'b0, rtc_ns}, 64'd0);
    chk("rst_prdata", {32'b0, PRDATA}, 64'd0);
    PRESET = 1'b0;
    apb_rd("rst_control", 8'h00, 32'd0);
    apb_rd("rst_inc_ns", 8'h08, 32'd8);
    apb_rd("rst_inc_frac", 8'h0C, 32'd0);
    apb_rd("rst_status", 8'h04, 32'd0);

    // rollover after 18 ticks of 8 ns
    load_tod(48'h1111_1111_1111, 32'd999_999_856);
    apb_wr(8'h00, 32'h3);
    tick(17);
    chk("pre_roll_ns", {32'b0, rtc_ns}, 64'd999_999_992);
    chk("pre_roll_pps", {63'b0, rtc_pps}, 64'd0);
    tick(1);
    chk("roll_sec", {16'b0, rtc_sec}, 64'h1111_1111_1112);
    chk("roll_ns", {32'b0, rtc_ns}, 64'd0);
    chk("roll_pps", {63'b0, rtc_pps}, 64'd1);
    chk("roll_irq", {63'b0, IRQ}, 64'd1);
    tick(1);
    chk("pps_once", {63'b0, rtc_pps}, 64'd0);
    apb_wr(8'h04, 32'h1);
    chk("w1c_irq", {63'b0, IRQ}, 64'd0);

    // W1C lands on the rollover edge
    apb_wr(8'h00, 32'h0);
    load_tod(48'd7, 32'd999_999_976);
    apb_wr(8'h00, 32'h1);
    apb_wr(8'h04, 32'h1);
    chk("coll_pps", {63'b0, rtc_pps}, 64'd1);
    chk("coll_sec", {16'b0, rtc_sec}, 64'd8);
    apb_rd("coll_status", 8'h04, 32'd1);
    apb_wr(8'h04, 32'h1);
    apb_rd("clr_status", 8'h04, 32'd0);
    apb_wr(8'h00, 32'h0);

    // half-ns fractional increment
    apb_wr(8'h0C, 32'h8000_0000);
    load_tod(48'd0, 32'd0);
    apb_wr(8'h00, 32'h1);
    ns_q.push_back(32'd8);
    ns_q.push_back(32'd17);
    ns_q.push_back(32'd25);
    ns_q.push_back(32'd34);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("frac_ns", {32'b0, rtc_ns}, {32'b0, ns_q.pop_front()});
    end
    apb_wr(8'h00, 32'h0);
    apb_wr(8'h0C, 32'h0);

    // negative then clamped positive adjust while disabled
    load_tod(48'd5, 32'd50);
    apb_wr(8'h20, 32'h8000_0064);
    chk("adj_pending", {32'b0, rtc_ns}, 64'd50);
    tick(1);
    chk("adjn_sec", {16'b0, rtc_sec}, 64'd4);
    chk("adjn_ns", {32'b0, rtc_ns}, 64'd999_999_950);
    chk("adjn_pps", {63'b0, rtc_pps}, 64'd0);
    apb_wr(8'h20, 32'h3FFF_FFFF);
    tick(1);
    chk("adjp_sec", {16'b0, rtc_sec}, 64'd5);
    chk("adjp_ns", {32'b0, rtc_ns}, 64'd999_999_949);
    chk("adjp_pps", {63'b0, rtc_pps}, 64'd1);
    apb_wr(8'h04, 32'h1);

    // oversize shadow ns clamps on load only
    load_tod(48'd1, 32'hFFFF_FFFF);
    tick(1);
    chk("ld_clamp", {32'b0, rtc_ns}, 64'd999_999_999);
    apb_rd("sh_ns_raw", 8'h18, 32'hFFFF_FFFF);

    // snapshot captures the value before the write-edge tick
    load_tod(48'h1234_5678_9ABC, 32'd1000);
    apb_wr(8'h00, 32'h1);
    apb_wr(8'h1C, 32'h2);
    chk("snap_live", {32'b0, rtc_ns}, 64'd1024);
    apb_wr(8'h00, 32'h0);
    apb_rd("snap_hi", 8'h10, 32'h1234);
    apb_rd("snap_lo", 8'h14, 32'h5678_9ABC);
    apb_rd("snap_ns", 8'h18, 32'd1016);

    // load and snapshot together: load wins
    apb_wr(8'h18, 32'd500);
    apb_wr(8'h1C, 32'h3);
    tick(1);
    chk("ldsnap_ns", {32'b0, rtc_ns}, 64'd500);
    apb_rd("ldsnap_sh", 8'h18, 32'd500);

    apb_rd("rd_todcmd", 8'h1C, 32'd0);
    apb_rd("rd_adj", 8'h20, 32'd0);
    apb_rd("rd_unmapped", 8'h40, 32'd0);

    // soft reset while running
    apb_wr(8'h08, 32'd5);
    apb_wr(8'h00, 32'h3);
    tick(5);
    apb_wr(8'h00, 32'h8000_0000);
    chk("srst_ns", {32'b0, rtc_ns}, 64'd0);
    chk("srst_sec", {16'b0, rtc_sec}, 64'd0);
    apb_rd("srst_control", 8'h00, 32'd0);
    apb_rd("srst_inc_ns", 8'h08, 32'd8);
    apb_rd("srst_sh_ns", 8'h18, 32'd0);
    tick(2);
    chk("srst_hold", {32'b0, rtc_ns}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
